// File: rtl/fir_out_requant.sv
// FIR output stage: decimate, round half-up, saturate to OUT_W, then buffer in a
// first-word fall-through FIFO with a valid/ready output and sticky status flags.
module fir_out_requant #(
  parameter int IN_W       = 32,
  parameter int OUT_W      = 16,
  parameter int SHIFT      = 15,
  parameter int DECIM      = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic signed [IN_W-1:0]          in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [OUT_W-1:0]         out_data,
  output logic [$clog2(FIFO_DEPTH):0]     fill_level,
  output logic                            sat_flag,
  output logic                            ovf_flag,
  input  logic                            flag_clr
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int EW   = IN_W + 1;

  localparam logic signed [EW-1:0] HALF_V = EW'(64'sd1 <<< (SHIFT - 1));
  localparam logic signed [EW-1:0] MAX_V  = EW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [EW-1:0] MIN_V  = EW'(-(64'sd1 <<< (OUT_W - 1)));

  logic [CW-1:0]          dec_q, dec_d;
  logic                   pipe_vld_q, pipe_vld_d;
  logic [OUT_W-1:0]       pipe_data_q, pipe_data_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]        count_q, count_d;
  logic [OUT_W-1:0]       last_q, last_d;
  logic                   sat_q, sat_d, ovf_q, ovf_d;
  logic [OUT_W-1:0]       mem_q [FIFO_DEPTH];

  logic                   keep_s, clamp_s, full_s, pop_s, wr_en_s, drop_s;
  logic signed [EW-1:0]   ext_s, rnd_s, shr_s;
  logic [OUT_W-1:0]       q_s;

  assign keep_s = in_valid && (dec_q == '0);
  assign full_s = (count_q == CNTW'(FIFO_DEPTH));
  assign pop_s  = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en_s = pipe_vld_q && (!full_s || pop_s);
  assign drop_s  = pipe_vld_q && full_s && !pop_s;

  assign out_valid  = (count_q != '0);
  assign out_data   = out_valid ? $signed(mem_q[rd_ptr_q]) : $signed(last_q);
  assign fill_level = count_q;
  assign sat_flag   = sat_q;
  assign ovf_flag   = ovf_q;

  // Round half-up in IN_W+1 bits, arithmetic shift, clamp to the output range.
  always_comb begin
    ext_s   = $signed({in_data[IN_W-1], in_data});
    rnd_s   = ext_s + HALF_V;
    shr_s   = rnd_s >>> SHIFT;
    clamp_s = 1'b0;
    q_s     = shr_s[OUT_W-1:0];
    if (shr_s > MAX_V) begin
      clamp_s = 1'b1;
      q_s     = MAX_V[OUT_W-1:0];
    end else if (shr_s < MIN_V) begin
      clamp_s = 1'b1;
      q_s     = MIN_V[OUT_W-1:0];
    end else begin
      clamp_s = 1'b0;
    end
  end

  // Next-state for decimator, pipeline stage, FIFO pointers and flags.
  always_comb begin
    dec_d       = dec_q;
    pipe_vld_d  = keep_s;
    pipe_data_d = pipe_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_d      = last_q;
    sat_d       = sat_q;
    ovf_d       = ovf_q;

    if (in_valid) begin
      dec_d = (dec_q == CW'(DECIM - 1)) ? '0 : dec_q + CW'(1);
    end else begin
      dec_d = dec_q;
    end

    if (keep_s) begin
      pipe_data_d = q_s;
    end else begin
      pipe_data_d = pipe_data_q;
    end

    if (wr_en_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase

    // Clear first so that a same-cycle set event wins.
    if (flag_clr) begin
      sat_d = 1'b0;
      ovf_d = 1'b0;
    end else begin
      sat_d = sat_q;
      ovf_d = ovf_q;
    end
    if (keep_s && clamp_s) begin
      sat_d = 1'b1;
    end else begin
      sat_d = sat_d;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_q       <= '0;
      pipe_vld_q  <= 1'b0;
      pipe_data_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_q      <= '0;
      sat_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      pipe_vld_q  <= pipe_vld_d;
      pipe_data_q <= pipe_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_q      <= last_d;
      sat_q       <= sat_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage array; entries are only observed while counted as occupied.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= pipe_data_q;
    end
  end

endmodule
